// File: rtl/systolic_operand_feeder_if.sv
// Operand stream into the feeder (row/column beats) and the skewed wavefront out of it.
interface systolic_operand_feeder_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic [2*N*DW-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   out_a;
    logic [N*DW-1:0]   out_b;
    logic              out_valid;

    modport master (output in_data, in_valid, input in_ready, out_a, out_b, out_valid);
    modport slave  (input in_data, in_valid, output in_ready, out_a, out_b, out_valid);
endinterface

// File: rtl/systolic_operand_feeder.sv
// Buffers an NxN A (by row) and B (by column), then streams them as a skewed
// wavefront into the PE array edge: lane i lags lane 0 by i steps.
module systolic_feeder_lane #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int LANE = 0,
    parameter int TW   = 3
) (
    input  logic [N-1:0][DW-1:0] vec,
    input  logic [TW-1:0]        t,
    output logic [DW-1:0]        elem
);
    // Element t-LANE of this lane's vector, zero outside the wavefront.
    always_comb begin
        elem = '0;
        for (int k = 0; k < N; k++)
            if (int'(t) == k + LANE) elem = vec[k];
    end
endmodule

module systolic_operand_feeder #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    systolic_operand_feeder_if.slave    bus,
    input  logic                        start,
    input  logic                        feed_hold,
    input  logic                        flush,
    output logic                        load_done,
    output logic                        feed_done,
    output logic                        busy
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(2 * N);

    typedef enum logic [1:0] {LOAD = 2'd0, LOADED = 2'd1, FEED = 2'd2} state_t;
    typedef struct packed {
        logic [N-1:0][DW-1:0] a_row;
        logic [N-1:0][DW-1:0] b_col;
    } beat_t;

    state_t state, state_nxt;
    beat_t  beat;
    logic [CW-1:0] cnt;
    logic [TW-1:0] t, t_nxt;
    // a_buf[i] is row i of A; b_buf[j] is column j of B, so both lanes index the same way.
    logic [N-1:0][N-1:0][DW-1:0] a_buf, b_buf;
    logic [N-1:0][DW-1:0] lane_a, lane_b, a_nxt, b_nxt;
    logic accept, last_step, valid_nxt, done_nxt;

    assign beat      = bus.in_data;
    assign accept    = (state == LOAD) && bus.in_valid && bus.in_ready && !flush;
    assign last_step = (t == TW'(2 * N - 2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= LOAD;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) state_nxt = LOAD;
        else begin
            case (state)
                LOAD:    if (accept && cnt == CW'(N - 1)) state_nxt = LOADED;
                LOADED:  if (start) state_nxt = FEED;
                FEED:    if (!feed_hold && last_step) state_nxt = LOAD;
                default: state_nxt = LOAD;
            endcase
        end
    end

    // Next values of the registered outputs; lanes look at the step about to be shown.
    always_comb begin
        t_nxt     = '0;
        valid_nxt = 1'b0;
        if (state_nxt == FEED) begin
            valid_nxt = !feed_hold;
            if (state == FEED) t_nxt = feed_hold ? t : t + TW'(1);
        end
        done_nxt = (state == FEED) && (state_nxt == LOAD) && !flush;
        a_nxt    = (state_nxt == FEED) ? lane_a : '0;
        b_nxt    = (state_nxt == FEED) ? lane_b : '0;
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        systolic_feeder_lane #(.N(N), .DW(DW), .LANE(i), .TW(TW)) u_a (
            .vec(a_buf[i]), .t(t_nxt), .elem(lane_a[i])
        );
        systolic_feeder_lane #(.N(N), .DW(DW), .LANE(i), .TW(TW)) u_b (
            .vec(b_buf[i]), .t(t_nxt), .elem(lane_b[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt           <= '0;
            t             <= '0;
            a_buf         <= '0;
            b_buf         <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_a     <= '0;
            bus.out_b     <= '0;
            bus.out_valid <= 1'b0;
            load_done     <= 1'b0;
            feed_done     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            if (accept) begin
                a_buf[cnt] <= beat.a_row;
                b_buf[cnt] <= beat.b_col;
            end
            if (flush || state != LOAD)          cnt <= '0;
            else if (accept && cnt != CW'(N - 1)) cnt <= cnt + CW'(1);
            t             <= t_nxt;
            bus.in_ready  <= (state_nxt == LOAD);
            bus.out_a     <= a_nxt;
            bus.out_b     <= b_nxt;
            bus.out_valid <= valid_nxt;
            load_done     <= (state_nxt == LOADED);
            feed_done     <= done_nxt;
            busy          <= (state_nxt == FEED);
        end
    end
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder: matrix model plus wavefront scoreboard.
module tb_systolic_operand_feeder;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int W  = N * DW;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } step_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0, feed_hold = 1'b0, flush = 1'b0;
    logic load_done, feed_done, busy;

    int errors = 0;
    int checks = 0;
    int vcount = 0;
    logic [DW-1:0] m_a [N][N];
    logic [DW-1:0] m_b [N][N];
    step_t expq[$];

    systolic_operand_feeder_if #(.N(N), .DW(DW)) bus ();

    systolic_operand_feeder #(.N(N), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .start(start), .feed_hold(feed_hold), .flush(flush),
        .load_done(load_done), .feed_done(feed_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A[i][k] = 16i+k+off, B[k][j] = 0x80+16j+k+off; beat r = row r of A, column r of B.
    function automatic logic [2*W-1:0] mk_beat(input int off, input int r);
        logic [W-1:0] ar, bc;
        for (int k = 0; k < N; k++) begin
            ar[k*DW +: DW] = 8'(16 * r + k + off);
            bc[k*DW +: DW] = 8'(128 + 16 * r + k + off);
        end
        return {ar, bc};
    endfunction

    task automatic model_store(input logic [2*W-1:0] bt, input int r);
        for (int k = 0; k < N; k++) begin
            m_a[r][k] = bt[W + k*DW +: DW];
            m_b[k][r] = bt[k*DW +: DW];
        end
    endtask

    function automatic step_t exp_step(input int t);
        step_t s;
        s.a = '0;
        s.b = '0;
        for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < N) begin
                s.a[i*DW +: DW] = m_a[i][t-i];
                s.b[i*DW +: DW] = m_b[t-i][i];
            end
        end
        return s;
    endfunction

    task automatic push_feed();
        for (int t = 0; t < 2 * N - 1; t++) expq.push_back(exp_step(t));
    endtask

    task automatic load_beats(input int off, input int r0, input int r1);
        bus.in_valid = 1'b1;
        for (int r = r0; r <= r1; r++) begin
            bus.in_data = mk_beat(off, r);
            chk("ready_during_load", bus.in_ready, 1);
            model_store(bus.in_data, r);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_feed(input int hold_at, input int hold_len, input int exp_cyc);
        int cyc, v0;
        step_t hs;
        hs = exp_step(hold_len > 0 ? hold_at : 0);
        push_feed();
        v0 = vcount;
        cyc = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("feed_busy", busy, 1);
        chk("feed_load_done_low", load_done, 0);
        while (!feed_done && cyc < 40) begin
            if (hold_len > 0 && cyc == hold_at) feed_hold = 1'b1;
            if (hold_len > 0 && cyc == hold_at + hold_len) feed_hold = 1'b0;
            step();
            cyc++;
            if (hold_len > 0 && cyc > hold_at && cyc <= hold_at + hold_len) begin
                chk("hold_valid", bus.out_valid, 0);
                chk("hold_a", bus.out_a, hs.a);
                chk("hold_b", bus.out_b, hs.b);
            end
        end
        feed_hold = 1'b0;
        chk("feed_cycles", cyc, exp_cyc);
        chk("feed_done_pulse", feed_done, 1);
        chk("end_busy", busy, 0);
        chk("end_valid", bus.out_valid, 0);
        chk("end_ready", bus.in_ready, 1);
        chk("end_a_zero", bus.out_a, 0);
        chk("valid_count", vcount - v0, 2 * N - 1);
        chk("queue_drained", expq.size(), 0);
        expq.delete();
        step();
        chk("feed_done_one_cycle", feed_done, 0);
    endtask

    // Scoreboard: every live wavefront step must match the next expected step.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid) begin
            vcount++;
            chk("live_step_expected", expq.size() != 0, 1);
            if (expq.size() != 0) begin
                step_t e;
                e = expq.pop_front();
                chk("wave_a", bus.out_a, e.a);
                chk("wave_b", bus.out_b, e.b);
            end
        end
    end

    initial begin
        int v0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_a", bus.out_a, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("ready_after_reset", bus.in_ready, 1);

        // Plain load and feed with literal pins on the wavefront.
        load_beats(0, 0, 3);
        chk("ready_drop", bus.in_ready, 0);
        chk("load_done_rise", load_done, 1);
        push_feed();
        v0 = vcount;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("s0_valid", bus.out_valid, 1);
        chk("s0_busy", busy, 1);
        chk("s0_load_done", load_done, 0);
        chk("s0_a_lit", bus.out_a, 32'h0000_0000);
        chk("s0_b_lit", bus.out_b, 32'h0000_0080);
        step();
        chk("s1_a_lit", bus.out_a, 32'h0000_1001);
        chk("s1_b_lit", bus.out_b, 32'h0000_9081);
        repeat (5) step();
        chk("s6_a_lit", bus.out_a, 32'h3300_0000);
        chk("s6_b_lit", bus.out_b, 32'hB300_0000);
        step();
        chk("done_pulse", feed_done, 1);
        chk("done_valid", bus.out_valid, 0);
        chk("done_busy", busy, 0);
        chk("done_ready", bus.in_ready, 1);
        chk("done_b_zero", bus.out_b, 0);
        chk("first_valid_count", vcount - v0, 7);
        step();
        chk("done_drop", feed_done, 0);

        // Three-cycle stall at step 2.
        load_beats(6, 0, 3);
        chk("load_done_hold_test", load_done, 1);
        run_feed(2, 3, 10);

        // in_valid held high through LOADED and FEED; first beat after the feed replaces row 0.
        load_beats(1, 0, 3);
        bus.in_data  = mk_beat(8'h40, 0);
        bus.in_valid = 1'b1;
        step();
        chk("loaded_ready_low", bus.in_ready, 0);
        step();
        chk("loaded_still_done", load_done, 1);
        run_feed(0, 0, 7);
        model_store(mk_beat(8'h40, 0), 0);
        chk("ready_after_overwrite", bus.in_ready, 1);
        chk("no_load_done_1beat", load_done, 0);
        load_beats(1, 1, 3);
        chk("reload_done", load_done, 1);
        run_feed(0, 0, 7);

        // Flush at step 3.
        load_beats(2, 0, 3);
        push_feed();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("pre_flush_valid", bus.out_valid, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        expq.delete();
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_ready", bus.in_ready, 1);
        chk("flush_busy", busy, 0);
        chk("flush_load_done", load_done, 0);
        chk("flush_a_zero", bus.out_a, 0);
        chk("flush_no_done", feed_done, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("post_flush_no_done", feed_done, 0);
            chk("post_flush_valid", bus.out_valid, 0);
        end
        load_beats(3, 0, 3);
        chk("flush_reload_done", load_done, 1);
        run_feed(0, 0, 7);

        // Reset mid-load, then start coinciding with the final beat is ignored.
        load_beats(4, 0, 1);
        reset_n = 1'b0;
        #2;
        chk("async_rst_ready", bus.in_ready, 0);
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_load_done", load_done, 0);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("ready_after_rst2", bus.in_ready, 1);
        load_beats(5, 0, 2);
        chk("three_beats_not_done", load_done, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = mk_beat(5, 3);
        model_store(bus.in_data, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        bus.in_valid = 1'b0;
        chk("last_beat_done", load_done, 1);
        chk("start_ignored_busy", busy, 0);
        chk("start_ignored_valid", bus.out_valid, 0);
        step();
        chk("still_loaded", load_done, 1);
        run_feed(0, 0, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
- Parametrised successor to the fixed 4x4 operand loader. Accepts an NxN A matrix (one row per beat) and an NxN B matrix (one column per beat) over a single ready/valid stream.
- Buffers both matrices, then on `start` streams them into the systolic MAC array edge as a time-skewed wavefront: lane i is delayed by i cycles.
- Sits between the rv protocol front end and the PE array. Supports stall and flush.

Parameters:
- N, 4, array dimension: rows of A, columns of B, lanes per edge.
- DW, 8, element width in bits.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- in_data  in  2*N*DW  [2*N*DW-1:N*DW] = A row; [N*DW-1:0] = B column; element k at [k*DW +: DW] of each half
- in_valid  in  1  source beat valid
- in_ready  out  1  feeder can accept a beat
- start  in  1  begin feeding the buffered matrices
- feed_hold  in  1  array stall; freezes the wavefront
- flush  in  1  synchronous abort back to LOAD
- out_a  out  N*DW  lane i at [i*DW +: DW], into PE row i
- out_b  out  N*DW  lane j at [j*DW +: DW], into PE column j
- out_valid  out  1  out_a/out_b carry a live wavefront step
- load_done  out  1  level: both matrices buffered, waiting for start
- feed_done  out  1  one-cycle pulse: wavefront complete
- busy  out  1  state is FEED

Behaviour:
- Reset (reset_n low, async): state=LOAD, beat count=0, step t=0, buffers cleared. in_ready, out_a, out_b, out_valid, load_done, feed_done, busy all 0. in_ready goes 1 on the first rising edge after reset_n rises.
- All outputs are registered. in_ready is registered as (next state == LOAD).
- LOAD state:
  - A beat is accepted on an edge with in_valid && in_ready.
  - Row half is stored to A[cnt][*]; column half is stored to B[*][cnt]. cnt increments; the count is log2-sized and saturates at N-1.
  - On the edge accepting beat N-1: go to LOADED. in_ready drops and load_done rises on that same edge.
  - in_valid while in_ready=0 is ignored and never stored.
- LOADED state:
  - Holds until start=1.
  - On the edge sampling start: go to FEED, t=0, out_valid=1, load_done=0, busy=1, outputs = step 0.
  - start in any other state is ignored.
- FEED, step t (0..2N-2):
  - out_a lane i = A[i][t-i] if 0 <= t-i < N, else 0.
  - out_b lane j = B[t-j][j] if 0 <= t-j < N, else 0.
  - Each edge with feed_hold=0 advances t. With feed_hold=1, t and outputs hold and out_valid=0 for those cycles; out_valid returns to 1 when hold releases, with the same step.
  - On the edge after step 2N-2 is presented with feed_hold=0: outputs go to 0, out_valid=0, busy=0, feed_done=1 for one cycle, state=LOAD, cnt=0, in_ready=1.
  - Total: 2N-1 valid cycles per matrix pair with no stalls.
- flush=1 in any state:
  - Next edge: state=LOAD, cnt=0, t=0.
  - out_valid=0, load_done=0, busy=0, outputs zeroed, no feed_done.
  - Buffer contents are not cleared; they are overwritten by the next load.
  - flush has priority over start, feed_hold and beat acceptance on the same edge.
- Simultaneous start and the final LOAD beat: start is ignored because state is not yet LOADED.
- Reset asserted mid-FEED aborts immediately to reset values.

Test Plan (N=4, DW=8; A[i][k]=16*i+k, B[k][j]=0x80+16*j+k; beats r=0..3 carry A row r and B column r):
- Reset, then 4 back-to-back beats -> in_ready=1 for 4 cycles then 0; load_done=1 on the edge accepting beat 3.
- Start after load -> step 0: out_a={0,0,0,0x00}, out_b lane0=0x80. Step 1: out_a lane0=0x01, lane1=0x10; out_b lane0=0x81, lane1=0x90. Step 6: only lane3 nonzero, out_a=0x33, out_b=0xB3. feed_done pulses 1 cycle after step 6; 7 valid cycles total.
- feed_hold=1 for 3 cycles at step 2 -> out_valid=0 for 3 cycles, step 2 values re-presented, 7 valid cycles total, feed_done delayed by 3.
- in_valid held high through LOADED and FEED -> no beat accepted until feed_done. The next accepted beat overwrites row 0, and a second feed reflects the new data.
- flush asserted at step 3 -> next cycle out_valid=0, in_ready=1, no feed_done; a fresh 4-beat load then start gives a correct 7-step feed.
- reset_n pulsed low mid-LOAD after 2 beats -> all outputs 0 asynchronously; load_done requires 4 new beats afterwards.
